// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine change path: coin encodings,
// the item price and the dispenser state encoding.
package vm_pkg;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_1    = 3'b001;
  localparam logic [2:0] COIN_2    = 3'b010;
  localparam logic [2:0] COIN_5    = 3'b101;

  localparam int PRICE = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAY  = 2'd1,
    DONE = 2'd2
  } disp_state_t;

endpackage

// File: rtl/vm_coin_select.sv
// Combinational greedy coin picker: returns the largest coin that fits in
// the remaining change and is still in stock.
module vm_coin_select
  import vm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] remaining,
  input  logic         has_1,
  input  logic         has_2,
  input  logic         has_5,
  output logic [2:0]   coin,
  output logic [W-1:0] value,
  output logic         found
);

  localparam logic [W-1:0] V1 = W'(1);
  localparam logic [W-1:0] V2 = W'(2);
  localparam logic [W-1:0] V5 = W'(5);

  // Priority 5 > 2 > 1; nothing is picked when remaining is zero.
  always_comb begin
    coin  = COIN_NONE;
    value = '0;
    found = 1'b0;
    if (has_5 && remaining >= V5) begin
      coin  = COIN_5;
      value = V5;
      found = 1'b1;
    end else if (has_2 && remaining >= V2) begin
      coin  = COIN_2;
      value = V2;
      found = 1'b1;
    end else if (has_1 && remaining >= V1) begin
      coin  = COIN_1;
      value = V1;
      found = 1'b1;
    end
  end

endmodule

// File: rtl/vending_change_dispenser.sv
// Change dispenser: pays out the requested change one coin per clock using a
// greedy picker. Optional macro VM_CHANGE_INVENTORY_EN builds per-denomination
// stock counters (with refill and short-change reporting); without it the
// supply is unlimited and the stock outputs are tied to INIT_STOCK.
module vending_change_dispenser
  import vm_pkg::*;
#(
  parameter int CHANGE_W   = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                change_req,
  input  logic [CHANGE_W-1:0] change_amt,
  input  logic                refill,
  output logic                busy,
  output logic                coin_valid,
  output logic [2:0]          coin_out,
  output logic                done,
  output logic                short,
  output logic [CHANGE_W-1:0] remaining,
  output logic [STOCK_W-1:0]  stock_1,
  output logic [STOCK_W-1:0]  stock_2,
  output logic [STOCK_W-1:0]  stock_5
);

  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

  disp_state_t         state_q, state_d;
  logic [CHANGE_W-1:0] rem_d, rem_after, sel_rem, val_a;
  logic [2:0]          coin_a, co_d;
  logic                found_a, found_b;
  logic                busy_d, cv_d, done_d, short_d;
  logic                in_idle, in_pay, pay_coin;
  logic                has1_a, has2_a, has5_a, has1_b, has2_b, has5_b;
  logic [2:0]          unused_coin_b;
  logic [CHANGE_W-1:0] unused_val_b;

  assign in_idle   = (state_q == IDLE);
  assign in_pay    = (state_q == PAY);
  assign pay_coin  = in_pay && found_a;
  // In IDLE the picker looks at the incoming request so a request that cannot
  // be paid at all finishes without an empty PAY cycle.
  assign sel_rem   = in_idle ? change_amt : remaining;
  assign rem_after = remaining - val_a;

`ifdef VM_CHANGE_INVENTORY_EN
  localparam bit INV_EN = 1'b1;

  logic [STOCK_W-1:0] stk1_q, stk2_q, stk5_q;
  logic [STOCK_W-1:0] stk1_eff, stk2_eff, stk5_eff;
  logic [STOCK_W-1:0] stk1_nxt, stk2_nxt, stk5_nxt;

  // A refill together with a request is applied before the request is judged.
  assign stk1_eff = (in_idle && refill) ? STOCK_INIT : stk1_q;
  assign stk2_eff = (in_idle && refill) ? STOCK_INIT : stk2_q;
  assign stk5_eff = (in_idle && refill) ? STOCK_INIT : stk5_q;

  // The picker only chooses a non-empty denomination, so these never wrap.
  assign stk1_nxt = stk1_eff - STOCK_W'(pay_coin && coin_a == COIN_1);
  assign stk2_nxt = stk2_eff - STOCK_W'(pay_coin && coin_a == COIN_2);
  assign stk5_nxt = stk5_eff - STOCK_W'(pay_coin && coin_a == COIN_5);

  assign has1_a = (stk1_eff != '0);
  assign has2_a = (stk2_eff != '0);
  assign has5_a = (stk5_eff != '0);
  assign has1_b = (stk1_nxt != '0);
  assign has2_b = (stk2_nxt != '0);
  assign has5_b = (stk5_nxt != '0);

  // Stock counters: reload on reset, otherwise take refill/decrement result.
  always_ff @(posedge clk) begin
    if (reset) begin
      stk1_q <= STOCK_INIT;
      stk2_q <= STOCK_INIT;
      stk5_q <= STOCK_INIT;
    end else begin
      stk1_q <= stk1_nxt;
      stk2_q <= stk2_nxt;
      stk5_q <= stk5_nxt;
    end
  end

  assign stock_1 = stk1_q;
  assign stock_2 = stk2_q;
  assign stock_5 = stk5_q;
`else
  localparam bit INV_EN = 1'b0;

  logic unused_refill;
  assign unused_refill = refill;

  assign has1_a  = 1'b1;
  assign has2_a  = 1'b1;
  assign has5_a  = 1'b1;
  assign has1_b  = 1'b1;
  assign has2_b  = 1'b1;
  assign has5_b  = 1'b1;
  assign stock_1 = STOCK_INIT;
  assign stock_2 = STOCK_INIT;
  assign stock_5 = STOCK_INIT;
`endif

  // Coin for the current cycle (or the request being accepted).
  vm_coin_select #(.W(CHANGE_W)) u_sel_now (
    .remaining (sel_rem),
    .has_1     (has1_a),
    .has_2     (has2_a),
    .has_5     (has5_a),
    .coin      (coin_a),
    .value     (val_a),
    .found     (found_a)
  );

  // Look-ahead: can anything still be paid after this cycle's coin?
  vm_coin_select #(.W(CHANGE_W)) u_sel_next (
    .remaining (rem_after),
    .has_1     (has1_b),
    .has_2     (has2_b),
    .has_5     (has5_b),
    .coin      (unused_coin_b),
    .value     (unused_val_b),
    .found     (found_b)
  );

  // Next-state and next-output logic for the IDLE/PAY/DONE controller.
  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    cv_d    = 1'b0;
    co_d    = COIN_NONE;
    done_d  = 1'b0;
    short_d = short;
    case (state_q)
      IDLE: begin
        if (change_req) begin
          rem_d   = change_amt;
          short_d = 1'b0;
          state_d = found_a ? PAY : DONE;
        end
      end
      PAY: begin
        state_d = DONE;
        if (found_a) begin
          cv_d  = 1'b1;
          co_d  = coin_a;
          rem_d = rem_after;
          if (rem_after != '0 && found_b) state_d = PAY;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        short_d = INV_EN && (remaining != '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any payout without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      coin_valid <= 1'b0;
      coin_out   <= COIN_NONE;
      done       <= 1'b0;
      short      <= 1'b0;
      remaining  <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= busy_d;
      coin_valid <= cv_d;
      coin_out   <= co_d;
      done       <= done_d;
      short      <= short_d;
      remaining  <= rem_d;
    end
  end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Self-checking bench for vending_change_dispenser: table of fixed requests,
// hand-written corner sequences, and randomized requests against a greedy
// coin/stock model. Honours VM_CHANGE_INVENTORY_EN like the design.
module tb_vending_change_dispenser;

`ifdef VM_CHANGE_INVENTORY_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, change_req, refill;
  logic [3:0] change_amt;
  logic       busy, coin_valid, done, short;
  logic [2:0] coin_out;
  logic [3:0] remaining, stock_1, stock_2, stock_5;

  int checks = 0;
  int errors = 0;
  int mstock[3];     // model stock for coins 1, 2, 5
  int exp_q[$];      // expected coin values for the current request
  int exp_short;

  typedef struct {
    int amt;
    int n;
    int c[4];
  } vec_t;
  vec_t vecs[10];

  vending_change_dispenser #(.CHANGE_W(4), .STOCK_W(4), .INIT_STOCK(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .change_req (change_req),
    .change_amt (change_amt),
    .refill     (refill),
    .busy       (busy),
    .coin_valid (coin_valid),
    .coin_out   (coin_out),
    .done       (done),
    .short      (short),
    .remaining  (remaining),
    .stock_1    (stock_1),
    .stock_2    (stock_2),
    .stock_5    (stock_5)
  );

  always #5 clk = ~clk;

  function automatic int den(input int j);
    case (j)
      0: return 1;
      1: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int enc(input int v);
    case (v)
      1: return 3'b001;
      2: return 3'b010;
      5: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_stock(input string tag);
    chk({tag, "_stock_1"}, int'(stock_1), mstock[0]);
    chk({tag, "_stock_2"}, int'(stock_2), mstock[1]);
    chk({tag, "_stock_5"}, int'(stock_5), mstock[2]);
  endtask

  // Greedy payout from the rules: largest coin <= rem with stock left.
  task automatic model_req(input int amt, input bit rf);
    int rem;
    int pick;
    exp_q.delete();
    if (rf && INV) for (int j = 0; j < 3; j++) mstock[j] = 8;
    rem  = amt;
    pick = 0;
    while (rem > 0 && pick >= 0) begin
      pick = -1;
      for (int j = 2; j >= 0; j--)
        if (pick < 0 && den(j) <= rem && (!INV || mstock[j] > 0)) pick = j;
      if (pick >= 0) begin
        exp_q.push_back(den(pick));
        rem -= den(pick);
        if (INV) mstock[pick]--;
      end
    end
    exp_short = (INV && rem != 0) ? 1 : 0;
  endtask

  // Issue a request and check every cycle up to one past the done pulse.
  // poke=1 re-pulses change_req/refill during the payout.
  task automatic run_req(input int amt, input bit rf, input bit poke);
    int k;
    int sum;
    change_req = 1'b1;
    change_amt = amt[3:0];
    refill     = rf;
    @(posedge clk); #1;
    change_req = 1'b0;
    refill     = 1'b0;
    k   = exp_q.size();
    sum = 0;
    chk("acc_busy", int'(busy), 1);
    chk("acc_coin_valid", int'(coin_valid), 0);
    chk("acc_remaining", int'(remaining), amt);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      change_req = 1'b0;
      refill     = 1'b0;
      sum += exp_q[i];
      chk("coin_valid", int'(coin_valid), 1);
      chk("coin_out", int'(coin_out), enc(exp_q[i]));
      chk("pay_remaining", int'(remaining), amt - sum);
      chk("pay_busy", int'(busy), 1);
      chk("pay_done", int'(done), 0);
      if (poke && i == 0) begin
        change_req = 1'b1;
        change_amt = 4'd15;
        refill     = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("done_pulse", int'(done), 1);
    chk("done_short", int'(short), exp_short);
    chk("done_coin_valid", int'(coin_valid), 0);
    chk("done_coin_out", int'(coin_out), 0);
    chk("done_remaining", int'(remaining), amt - sum);
    chk("done_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("done_clear", int'(done), 0);
    chk("short_hold", int'(short), exp_short);
    chk("rem_hold", int'(remaining), amt - sum);
    chk("idle_coin_valid", int'(coin_valid), 0);
    chk_stock("post");
  endtask

  task automatic do_refill();
    refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
    if (INV) for (int j = 0; j < 3; j++) mstock[j] = 8;
    chk_stock("refill");
  endtask

  initial begin
    int amt;
    bit rf;

    vecs[0] = '{amt: 3,  n: 2, c: '{2, 1, 0, 0}};
    vecs[1] = '{amt: 4,  n: 2, c: '{2, 2, 0, 0}};
    vecs[2] = '{amt: 0,  n: 0, c: '{0, 0, 0, 0}};
    vecs[3] = '{amt: 8,  n: 3, c: '{5, 2, 1, 0}};
    vecs[4] = '{amt: 9,  n: 3, c: '{5, 2, 2, 0}};
    vecs[5] = '{amt: 15, n: 3, c: '{5, 5, 5, 0}};
    vecs[6] = '{amt: 14, n: 4, c: '{5, 5, 2, 2}};
    vecs[7] = '{amt: 1,  n: 1, c: '{1, 0, 0, 0}};
    vecs[8] = '{amt: 6,  n: 2, c: '{5, 1, 0, 0}};
    vecs[9] = '{amt: 13, n: 4, c: '{5, 5, 2, 1}};

    reset      = 1'b1;
    change_req = 1'b0;
    change_amt = 4'd0;
    refill     = 1'b0;
    for (int j = 0; j < 3; j++) mstock[j] = 8;
    exp_short = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_coin_out", int'(coin_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk_stock("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Table: each request arrives with a refill so it starts from full stock.
    for (int v = 0; v < 10; v++) begin
      model_req(vecs[v].amt, 1'b1);
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].c[i]);
      exp_short = 0;
      run_req(vecs[v].amt, 1'b1, 1'b0);
    end

    // Request and refill pulsed again while busy: ignored.
    model_req(8, 1'b1);
    run_req(8, 1'b1, 1'b1);

    // Reset on the second coin cycle of a 5,2,2 payout.
    model_req(9, 1'b1);
    change_req = 1'b1;
    change_amt = 4'd9;
    refill     = 1'b1;
    @(posedge clk); #1;
    change_req = 1'b0;
    refill     = 1'b0;
    @(posedge clk); #1;
    chk("t5_first_coin", int'(coin_out), 3'b101);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int j = 0; j < 3; j++) mstock[j] = 8;
    chk("t5_busy", int'(busy), 0);
    chk("t5_coin_valid", int'(coin_valid), 0);
    chk("t5_coin_out", int'(coin_out), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_short", int'(short), 0);
    chk("t5_remaining", int'(remaining), 0);
    chk_stock("t5");
    @(posedge clk); #1;
    chk("t5_no_done", int'(done), 0);
    chk("t5_idle_busy", int'(busy), 0);
    model_req(9, 1'b0);
    run_req(9, 1'b0, 1'b0);

`ifdef VM_CHANGE_INVENTORY_EN
    // Drain 2s and 1s, then a request that cannot be paid at all.
    do_refill();
    for (int i = 0; i < 6; i++) begin
      model_req(4, 1'b0);
      run_req(4, 1'b0, 1'b0);
    end
    chk("t4_stock_2", int'(stock_2), 0);
    chk("t4_stock_1", int'(stock_1), 0);
    model_req(3, 1'b0);
    run_req(3, 1'b0, 1'b0);
    chk("t4_short", int'(short), 1);
    chk("t4_remaining", int'(remaining), 3);
    do_refill();
    chk("t4_refill_2", int'(stock_2), 8);
`endif

    // Randomized requests against the model.
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 5) == 0) do_refill();
      amt = $urandom_range(0, 15);
      rf  = ($urandom_range(0, 7) == 0);
      model_req(amt, rf);
      run_req(amt, rf, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
